// File: rtl/v_hier_sched_pkg.sv
// Shared constants, index-width helper and lock-state encoding for the hierarchical scheduler.
package v_hier_sched_pkg;

    localparam int NREQ_MAX = 16;

    typedef enum logic {
        OPEN   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    // Bits needed to index n items (n >= 2).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/v_hier_rr_pick.sv
// Rotate-priority picker: first requester at or after ptr, wrapping modulo NREQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is consumed.
module v_hier_rr_pick
    import v_hier_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   winner,
    output logic            any
);

    int idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any && req[IW'(idx)]) begin
                any    = 1'b1;
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/v_hier_sched.sv
// Round-robin scheduler feeding one shared leaf; optional owner lock under V_HIER_SCHED_LOCK_EN.
// Latency: grant in cycle N, out_valid/out_data in cycle N+1.
// Backpressure: one-deep output stage; no grant while it is full and out_ready is low.
module v_hier_sched
    import v_hier_sched_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_LOCK = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    req_data,
    input  logic [NREQ-1:0]          lock,
    output logic [NREQ-1:0]          gnt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [clog2(NREQ)-1:0]   out_src
);

    localparam int IW = clog2(NREQ);

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + IW'(1);
    endfunction

    logic [IW-1:0]    ptr_q, ptr_d, pick_ptr, winner;
    logic [NREQ-1:0]  pick_req;
    logic             any, opp, load;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [IW-1:0]    out_src_q, out_src_d;

    v_hier_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req    (pick_req),
        .ptr    (pick_ptr),
        .winner (winner),
        .any    (any)
    );

    assign opp  = ~out_valid_q | out_ready;
    assign load = any & opp & ~reset;
    assign gnt  = load ? (NREQ'(1) << winner) : '0;

`ifdef V_HIER_SCHED_LOCK_EN
    localparam int CW = clog2(MAX_LOCK + 1);

    lock_state_e   state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          exit_lock;

    // Leaving the lock reopens arbitration in the same cycle, starting after the owner.
    always_comb begin
        exit_lock = (state_q == LOCKED) && opp &&
                    (!req[owner_q] || !lock[owner_q] || (cnt_q >= CW'(MAX_LOCK)));
        pick_ptr  = exit_lock ? next_idx(owner_q) : ptr_q;
        pick_req  = ((state_q == LOCKED) && !exit_lock) ? (req & (NREQ'(1) << owner_q)) : req;
        state_d   = exit_lock ? OPEN : state_q;
        owner_d   = owner_q;
        cnt_d     = exit_lock ? '0 : cnt_q;
        ptr_d     = pick_ptr;
        if (load) begin
            if (state_d == LOCKED) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                ptr_d = next_idx(winner);
                if (lock[winner]) begin
                    state_d = LOCKED;
                    owner_d = winner;
                    cnt_d   = CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OPEN;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end
`else
    logic unused_lock;
    localparam int UNUSED_MAX_LOCK = MAX_LOCK;
    assign unused_lock = ^lock;

    always_comb begin
        pick_ptr = ptr_q;
        pick_req = req;
        ptr_d    = load ? next_idx(winner) : ptr_q;
    end
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = req_data[int'(winner)*WIDTH +: WIDTH];
            out_src_d   = winner;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_v_hier_sched.sv
// Vector-table bench for v_hier_sched with a scoreboard for the output stage.
module tb_v_hier_sched;

    localparam int NREQ     = 4;
    localparam int WIDTH    = 8;
    localparam int MAX_LOCK = 3;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       lock = '0;
    logic [NREQ-1:0]       gnt;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [WIDTH-1:0]      out_data;
    logic [1:0]            out_src;

    v_hier_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_LOCK(MAX_LOCK)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .lock      (lock),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] lck;
        logic       rdy;
        logic       dsel;
        logic [3:0] egnt;
        int         evld;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [1:0]       src;
    } exp_t;

    vec_t vq[$];
    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    logic [WIDTH-1:0] base_d [4];
    logic [WIDTH-1:0] alt_d  [4];

    function automatic void add(input logic rst, input logic [3:0] rq, input logic [3:0] lk,
                                input logic rdy, input logic dsel, input logic [3:0] eg,
                                input int ev);
        vec_t v;
        v.rst = rst; v.req = rq; v.lck = lk; v.rdy = rdy;
        v.dsel = dsel; v.egnt = eg; v.evld = ev;
        vq.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic prev_rst;
        exp_t e;
        base_d = '{8'hFF, 8'h02, 8'hFD, 8'h04};   // -1, 2, -3, 4
        alt_d  = '{8'h9C, 8'h32, 8'hF9, 8'h7F};   // -100, 50, -7, 127

        // reset, full throughput
        add(1, 4'b1111, 4'b0000, 1, 0, 4'b0000, -1);
        add(1, 4'b1111, 4'b0000, 1, 0, 4'b0000, 0);
        add(0, 4'b1111, 4'b0000, 1, 0, 4'b0001, 0);
        add(0, 4'b1111, 4'b0000, 1, 0, 4'b0010, 1);
        add(0, 4'b1111, 4'b0000, 1, 0, 4'b0100, 1);
        add(0, 4'b1111, 4'b0000, 1, 0, 4'b1000, 1);
        add(0, 4'b1111, 4'b0000, 1, 0, 4'b0001, 1);
        // stall for 5 cycles with changing inputs, then seamless pop+load
        for (int k = 0; k < 5; k++) add(0, 4'b1111, 4'b0000, 0, 1, 4'b0000, 1);
        add(0, 4'b1111, 4'b0000, 1, 0, 4'b0010, 1);
        add(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 1);
        add(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0);
        // sparse requests and pointer wrap
        add(0, 4'b0100, 4'b0000, 1, 0, 4'b0100, 0);
        add(0, 4'b0010, 4'b0000, 1, 0, 4'b0010, 1);
        add(0, 4'b1000, 4'b0000, 1, 0, 4'b1000, 1);
        add(0, 4'b0011, 4'b0000, 1, 0, 4'b0001, 1);
        // reset while stalled with valid data
        add(0, 4'b1111, 4'b0000, 0, 1, 4'b0000, 1);
        add(1, 4'b1111, 4'b0000, 0, 1, 4'b0000, 1);
        add(0, 4'b1001, 4'b0000, 0, 0, 4'b0001, 0);
        add(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 1);
        add(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0);
`ifdef V_HIER_SCHED_LOCK_EN
        // lock held to MAX_LOCK, then lock dropped after one grant
        add(1, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0);
        add(0, 4'b0011, 4'b0001, 1, 0, 4'b0001, 0);
        add(0, 4'b0011, 4'b0001, 1, 0, 4'b0001, 1);
        add(0, 4'b0011, 4'b0001, 1, 0, 4'b0001, 1);
        add(0, 4'b0011, 4'b0001, 1, 0, 4'b0010, 1);
        add(0, 4'b0011, 4'b0001, 1, 0, 4'b0001, 1);
        add(0, 4'b0011, 4'b0000, 1, 0, 4'b0010, 1);
        add(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 1);
        add(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0);
`endif

        prev_rst = 1'b0;
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            reset     = vq[i].rst;
            req       = vq[i].req;
            lock      = vq[i].lck;
            out_ready = vq[i].rdy;
            for (int k = 0; k < NREQ; k++)
                req_data[k*WIDTH +: WIDTH] = vq[i].dsel ? alt_d[k] : base_d[k];
            #1;
            check($sformatf("gnt v%0d", i), 32'(gnt), 32'(vq[i].egnt));
            if (vq[i].evld >= 0)
                check($sformatf("out_valid v%0d", i), 32'(out_valid), 32'(vq[i].evld));
            if (prev_rst && vq[i].evld == 0) begin
                check($sformatf("rst out_data v%0d", i), 32'(out_data), 32'h0);
                check($sformatf("rst out_src v%0d", i), 32'(out_src), 32'h0);
            end
            if (out_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard v%0d: got unexpected output %0h expected none", i, out_data);
                end else begin
                    check($sformatf("out_data v%0d", i), 32'(out_data), 32'(sbq[0].data));
                    check($sformatf("out_src v%0d", i), 32'(out_src), 32'(sbq[0].src));
                    if (out_ready && !reset) void'(sbq.pop_front());
                end
            end
            if (vq[i].rst) begin
                sbq.delete();
            end else if (vq[i].egnt != 4'b0000) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (vq[i].egnt[k]) begin
                        e.data = req_data[k*WIDTH +: WIDTH];
                        e.src  = 2'(k);
                        sbq.push_back(e);
                    end
                end
            end
            prev_rst = vq[i].rst;
        end
        check("scoreboard drained", 32'(sbq.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
